// File: rtl/exc_trace_pkg.sv
// Shared record layout for the exception trace buffer: field widths, offsets and the packed record.
// Pure type/constant package; no logic.
package exc_trace_pkg;

  localparam int TS_W    = 32;
  localparam int CAUSE_W = 32;
  localparam int EPC_W   = 32;

  localparam int EPC_LSB   = 0;
  localparam int CAUSE_LSB = EPC_LSB + EPC_W;
  localparam int TS_LSB    = CAUSE_LSB + CAUSE_W;
  localparam int REC_W     = TS_LSB + TS_W;

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [CAUSE_W-1:0] cause;
    logic [EPC_W-1:0]   epc;
  } rec_t;

endpackage

// File: rtl/exc_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head visible the cycle after the first push.
// Push is refused when full unless a pop happens in the same cycle; clr overrides push and pop.
module exc_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_rdy && !empty && !clr;
    do_push  = push_vld && (!full || do_pop) && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Head is forced to zero when empty so stale storage never shows on the read port.
  assign pop_vld = !empty;
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/exc_trace_buf.sv
// Exception trace capture: timestamps each new CPU exception into a FWFT FIFO for host drain.
// Latency 2 cycles input->rd_valid; never stalls the core, overflow drops are counted and flagged.
module exc_trace_buf
  import exc_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CAUSE_W-1:0]       cause,
  input  logic [EPC_W-1:0]         EPC,
  input  logic                     clr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W-1:0]          rd_ts,
  output logic [CAUSE_W-1:0]       rd_cause,
  output logic [EPC_W-1:0]         rd_epc,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     ovf
);

  localparam logic [TS_W-1:0]   TS_ONE   = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [CAUSE_W-1:0] cause_q, cause_d, last_cause_q, last_cause_d;
  logic [EPC_W-1:0]   epc_q, epc_d, last_epc_q, last_epc_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;
  logic               evt_vld;
  logic               pop_vld;
  logic               drop;
  logic               fifo_full;
  rec_t               push_rec;
  logic [REC_W-1:0]   pop_dat;

  always_comb begin
    cause_d  = cause;
    epc_d    = EPC;
    evt_vld  = !clr && (cause_q != '0) &&
               ({cause_q, epc_q} != {last_cause_q, last_epc_q});
    pop_vld  = rd_valid && rd_ready;
    drop     = evt_vld && fifo_full && !pop_vld;

    push_rec.ts    = ts_q;
    push_rec.cause = cause_q;
    push_rec.epc   = epc_q;

    // A clean cycle forgets the last exception so an identical one re-triggers.
    last_cause_d = cause_q;
    last_epc_d   = (cause_q == '0) ? '0 : epc_q;
    ts_d         = ts_q + TS_ONE;
    drop_cnt_d   = drop_cnt_q;
    ovf_d        = ovf_q | drop;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_ONE;

    if (clr) begin
      last_cause_d = '0;
      last_epc_d   = '0;
      ts_d         = '0;
      drop_cnt_d   = '0;
      ovf_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      cause_q      <= '0;
      epc_q        <= '0;
      last_cause_q <= '0;
      last_epc_q   <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      last_cause_q <= last_cause_d;
      last_epc_q   <= last_epc_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  exc_fwft_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push_vld (evt_vld),
    .push_dat (push_rec),
    .pop_vld  (rd_valid),
    .pop_rdy  (rd_ready),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .level    (level)
  );

  assign rd_ts    = pop_dat[TS_LSB +: TS_W];
  assign rd_cause = pop_dat[CAUSE_LSB +: CAUSE_W];
  assign rd_epc   = pop_dat[EPC_LSB +: EPC_W];
  assign drop_cnt = drop_cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_exc_trace_buf.sv
// Bench for exc_trace_buf: queue-based reference model checked every cycle, plus directed literal cases.
module tb_exc_trace_buf;
  import exc_trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              clr = 1'b0;
  logic              rd_ready = 1'b0;
  logic [31:0]       cause = '0;
  logic [31:0]       epc = '0;
  logic              rd_valid;
  logic [TS_W-1:0]   rd_ts;
  logic [31:0]       rd_cause;
  logic [31:0]       rd_epc;
  logic [LVL_W-1:0]  level;
  logic [DROP_W-1:0] drop_cnt;
  logic              ovf;

  always #5 clk = ~clk;

  exc_trace_buf #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cause    (cause),
    .EPC      (epc),
    .clr      (clr),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_ts    (rd_ts),
    .rd_cause (rd_cause),
    .rd_epc   (rd_epc),
    .level    (level),
    .drop_cnt (drop_cnt),
    .ovf      (ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: inputs seen one edge ago are judged against the last exception;
  // records live in a plain queue.
  rec_t        mq[$];
  logic [31:0] m_ts = '0, m_pc = '0, m_pe = '0, m_lc = '0, m_le = '0;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit   ev;
    rec_t r;
    if (!rst_n) begin
      mq.delete();
      m_ts = '0; m_pc = '0; m_pe = '0; m_lc = '0; m_le = '0;
      m_drop = 0; m_ovf = 1'b0;
    end else begin
      ev = (m_pc != 0) && ((m_pc != m_lc) || (m_pe != m_le));
      if (clr) begin
        mq.delete();
        m_drop = 0; m_ovf = 1'b0; m_lc = '0; m_le = '0; m_ts = '0;
      end else begin
        if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
        if (ev) begin
          if (mq.size() < DEPTH) begin
            r.ts = m_ts; r.cause = m_pc; r.epc = m_pe;
            mq.push_back(r);
          end else begin
            if (m_drop < DROP_MAX) m_drop++;
            m_ovf = 1'b1;
          end
        end
        m_lc = m_pc;
        m_le = (m_pc != 0) ? m_pe : '0;
        m_ts = m_ts + 1;
      end
      m_pc = cause;
      m_pe = epc;
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", rd_valid, mq.size() != 0);
    chk("level", level, mq.size());
    chk("drop_cnt", drop_cnt, m_drop);
    chk("ovf", ovf, m_ovf);
    if (mq.size() != 0) begin
      chk("rd_ts", rd_ts, mq[0].ts);
      chk("rd_cause", rd_cause, mq[0].cause);
      chk("rd_epc", rd_epc, mq[0].epc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      cause = base + i;
      epc   = $urandom;
      step();
    end
    cause = '0;
    step();
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  logic [31:0] exp_c [DEPTH+3];
  logic [31:0] exp_e [DEPTH+3];
  int          rdy_pct;

  initial begin : stim
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_ts", rd_ts, 0);
    chk("reset_rd_cause", rd_cause, 0);
    chk("reset_rd_epc", rd_epc, 0);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (20) step();
    chk("t1_rd_valid", rd_valid, 0);
    chk("t1_level", level, 0);
    chk("t1_drop_cnt", drop_cnt, 0);

    // 2: held exception detected at ts=100
    do_clr();
    repeat (99) step();
    cause = 32'h30; epc = 32'h40;
    step();
    chk("t2_not_yet_valid", rd_valid, 0);
    step();
    chk("t2_rd_valid", rd_valid, 1);
    chk("t2_rd_ts", rd_ts, 100);
    chk("t2_rd_cause", rd_cause, 32'h30);
    chk("t2_rd_epc", rd_epc, 32'h40);
    repeat (3) step();
    chk("t2_level_one", level, 1);

    // 3: a clean cycle between identical exceptions re-triggers
    cause = 0; step();
    cause = 32'h30; step();
    cause = 0; step();
    chk("t3_level_two", level, 2);
    chk("t3_head_still_first", rd_ts, 100);
    rd_ready = 1'b1;
    step();
    chk("t3_second_ts", rd_ts, 106);
    step();
    rd_ready = 1'b0;
    chk("t3_drained", rd_valid, 0);

    // 4: overflow with no drain, then drain in order
    do_clr();
    for (int i = 0; i < DEPTH + 3; i++) begin
      cause = 32'h100 + i; epc = $urandom;
      exp_c[i] = cause; exp_e[i] = epc;
      step();
    end
    cause = 0; step(); step();
    chk("t4_level_full", level, DEPTH);
    chk("t4_drop_cnt", drop_cnt, 3);
    chk("t4_ovf", ovf, 1);
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_order_cause", rd_cause, exp_c[i]);
      chk("t4_order_epc", rd_epc, exp_e[i]);
      step();
    end
    rd_ready = 1'b0;
    chk("t4_empty", rd_valid, 0);

    // 5: push into full FIFO alongside a pop is accepted
    do_clr();
    burst(DEPTH, 32'h200);
    chk("t5_full", level, DEPTH);
    cause = 32'h300; epc = 32'h55;
    step();
    rd_ready = 1'b1; cause = 0;
    step();
    rd_ready = 1'b0;
    step();
    chk("t5_level_stays", level, DEPTH);
    chk("t5_no_drop", drop_cnt, 0);
    rd_ready = 1'b1;
    repeat (DEPTH - 1) step();
    chk("t5_last_cause", rd_cause, 32'h300);
    chk("t5_last_epc", rd_epc, 32'h55);
    step();
    rd_ready = 1'b0;
    chk("t5_drained", rd_valid, 0);

    // drop counter saturation
    do_clr();
    burst(DEPTH + 20, 32'h400);
    chk("sat_drop_cnt", drop_cnt, DROP_MAX);
    chk("sat_ovf", ovf, 1);

    // 6: reset mid-drain, then clr discarding a pending event
    do_clr();
    burst(7, 32'h500);
    rd_ready = 1'b1;
    step(); step();
    chk("t6_level_five", level, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rd_valid", rd_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_rd_ts", rd_ts, 0);
    chk("t6_rst_rd_cause", rd_cause, 0);
    chk("t6_rst_rd_epc", rd_epc, 0);
    rd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    burst(DEPTH + 2, 32'h600);
    chk("t6_pre_clr_drops", drop_cnt, 2);
    cause = 32'h700; epc = 32'h77;
    step();
    clr = 1'b1; cause = 0;
    step();
    clr = 1'b0;
    step(); step();
    chk("t6_clr_level", level, 0);
    chk("t6_clr_drop_cnt", drop_cnt, 0);
    chk("t6_clr_ovf", ovf, 0);
    chk("t6_clr_no_record", rd_valid, 0);

    // randomized traffic with varying drain rate, rare flushes and one reset
    rdy_pct = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) rdy_pct = $urandom_range(5, 95);
      if ($urandom_range(0, 1) == 0) begin
        cause = ($urandom_range(0, 9) < 3) ? 32'h0 : 32'($urandom_range(1, 3));
        epc   = 32'($urandom_range(0, 3)) << 2;
      end
      rd_ready = ($urandom_range(0, 99) < rdy_pct);
      clr      = ($urandom_range(0, 299) == 0);
      if (k == 1500) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    clr = 1'b0; rd_ready = 1'b0; cause = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
